// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks a 1-bit ALU slice over WIDTH bits LSB first,
// collects the result and flags, and runs a second LESS pass for SLT.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry_out,
    output logic             o_overflow,
    output logic             o_sl_a,
    output logic             o_sl_b,
    output logic             o_sl_cin,
    output logic             o_sl_binvert,
    output logic             o_sl_less,
    output logic [2:0]       o_sl_operation,
    input  logic             i_sl_result,
    input  logic             i_sl_cout
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SLT2 = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_set;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    logic             w_legal;
    logic             w_last;
    logic             w_ovf;
    logic             w_active;
    logic             w_inv_op;
    logic             w_zero_nxt;
    logic [WIDTH-1:0] w_result_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_legal        = (i_op <= OP_SLT);
        w_last         = (r_idx == IW'(WIDTH - 1));
        w_ovf          = r_carry ^ i_sl_cout;
        w_active       = (r_state == S_RUN) || (r_state == S_SLT2);
        w_inv_op       = (r_op == OP_SUB) || (r_op == OP_SLT);
        w_result_nxt   = r_result;
        w_result_nxt[r_idx] = i_sl_result;
        w_zero_nxt     = (w_result_nxt == '0);

        o_ready        = (r_state == S_IDLE);
        o_done         = (r_state == S_FIN);
        o_sl_a         = 1'b0;
        o_sl_b         = 1'b0;
        o_sl_cin       = 1'b0;
        o_sl_binvert   = 1'b0;
        o_sl_less      = 1'b0;
        o_sl_operation = 3'b000;

        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = w_legal ? S_RUN : S_FIN;
            S_RUN:  if (w_last)  w_state_nxt = (r_op == OP_SLT) ? S_SLT2 : S_FIN;
            S_SLT2: if (w_last)  w_state_nxt = S_FIN;
            default: w_state_nxt = S_IDLE;
        endcase

        // Slice controls come only from registered state; idle/fin keep them at 0
        if (w_active) begin
            o_sl_a       = r_a[r_idx];
            o_sl_b       = r_b[r_idx];
            o_sl_cin     = r_carry;
            o_sl_binvert = w_inv_op;
            if (r_state == S_SLT2) begin
                o_sl_operation = 3'b101;
                o_sl_less      = (r_idx == '0) ? r_set : 1'b0;
            end else begin
                case (r_op)
                    OP_AND:  o_sl_operation = 3'b000;
                    OP_OR:   o_sl_operation = 3'b001;
                    OP_XOR:  o_sl_operation = 3'b011;
                    OP_MOD:  o_sl_operation = 3'b100;
                    default: o_sl_operation = 3'b010;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_set    <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_result <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_idx    <= '0;
                        if (w_legal) begin
                            r_a     <= i_a;
                            r_b     <= i_b;
                            r_op    <= i_op;
                            r_carry <= (i_op == OP_SUB) || (i_op == OP_SLT);
                            r_zero  <= 1'b0;
                        end else begin
                            r_zero  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= i_sl_result;
                    r_carry         <= i_sl_cout;
                    if (w_last) begin
                        r_idx <= '0;
                        if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
                            r_cout <= i_sl_cout;
                            r_ovf  <= w_ovf;
                        end
                        // set = true sign of A-B, corrected for signed overflow
                        if (r_op == OP_SLT) r_set  <= i_sl_result ^ w_ovf;
                        else                r_zero <= w_zero_nxt;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_SLT2: begin
                    r_result[r_idx] <= i_sl_result;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_zero <= w_zero_nxt;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: r_zero <= (r_result == '0);
            endcase
        end
    end

    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_carry_out = r_cout;
    assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq at WIDTH=8 with a behavioural 1-bit slice; MOD is
// modelled by the slice as XNOR so its result is predictable.
module tb_alu_serial_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done, zero, cout, ovf;
    logic [W-1:0] result;
    logic         sl_a, sl_b, sl_cin, sl_binvert, sl_less;
    logic [2:0]   sl_operation;
    logic         sl_result, sl_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .o_ready(ready), .o_done(done), .o_result(result), .o_zero(zero),
        .o_carry_out(cout), .o_overflow(ovf),
        .o_sl_a(sl_a), .o_sl_b(sl_b), .o_sl_cin(sl_cin), .o_sl_binvert(sl_binvert),
        .o_sl_less(sl_less), .o_sl_operation(sl_operation),
        .i_sl_result(sl_result), .i_sl_cout(sl_cout)
    );

    // Behavioural 1-bit ALU slice
    logic bb;
    always_comb begin
        bb      = sl_b ^ sl_binvert;
        sl_cout = (sl_a & bb) | (sl_a & sl_cin) | (bb & sl_cin);
        case (sl_operation)
            3'b000:  sl_result = sl_a & bb;
            3'b001:  sl_result = sl_a | bb;
            3'b010:  sl_result = sl_a ^ bb ^ sl_cin;
            3'b011:  sl_result = sl_a ^ bb;
            3'b100:  sl_result = ~(sl_a ^ bb);
            3'b101:  sl_result = sl_less;
            default: sl_result = 1'b0;
        endcase
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        int           lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference computed from the operation definitions
    function automatic vec_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t   r;
        logic [W:0] s;
        r.op = o; r.a = x; r.b = y; r.c = 0; r.v = 0; r.lat = W + 1;
        case (o)
            4'd0: r.res = x & y;
            4'd1: r.res = x | y;
            4'd3: r.res = x ^ y;
            4'd4: r.res = ~(x ^ y);
            4'd2: begin
                s = {1'b0, x} + {1'b0, y};
                r.res = s[W-1:0]; r.c = s[W];
                r.v = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            4'd5: begin
                s = {1'b0, x} - {1'b0, y};
                r.res = s[W-1:0]; r.c = (x >= y);
                r.v = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            4'd6: begin
                r.res = ($signed(x) < $signed(y)) ? 1 : 0;
                r.lat = 2 * W + 1;
            end
            default: begin r.res = 0; r.lat = 1; end
        endcase
        r.z = (r.res == 0);
        return r;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        check({name, "_ready_wait"}, int'(ready), 1);
    endtask

    // Issue one op at a negedge, measure latency in cycles after the accept cycle
    task automatic run_op(input vec_t v, input string name);
        int k = 0;
        bit got = 0;
        wait_ready(name);
        start = 1; op = v.op; a = v.a; b = v.b;
        while (k < 40 && !got) begin
            @(negedge clk); k++;
            if (k == 1) start = 0;
            if (done) got = 1;
        end
        check({name, "_latency"}, k, v.lat);
        check({name, "_result"}, int'(result), int'(v.res));
        check({name, "_carry"}, int'(cout), int'(v.c));
        check({name, "_ovf"}, int'(ovf), int'(v.v));
        check({name, "_zero"}, int'(zero), int'(v.z));
        @(negedge clk);
        check({name, "_done_pulse"}, int'(done), 0);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   k;
        int   dcnt;
        bit   got;

        tbl[0] = '{4'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 9};
        tbl[1] = '{4'd5, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 9};
        tbl[2] = '{4'd5, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 9};
        tbl[3] = '{4'd6, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 17};
        tbl[4] = '{4'd6, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 17};
        tbl[5] = '{4'd3, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 9};
        tbl[6] = '{4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        tbl[7] = '{4'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 9};
        tbl[8] = '{4'd4, 8'h0F, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 9};
        tbl[9] = '{4'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 9};

        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'({zero, cout, ovf}), 0);
        check("rst_sl", int'({sl_a, sl_b, sl_cin, sl_binvert, sl_less, sl_operation}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 8));
            if (o > 4'd6) o = 4'($urandom_range(7, 15));
            v = model(o, W'($urandom), W'($urandom));
            run_op(v, $sformatf("rnd%0d_op%0d", i, o));
        end

        // START pulsed mid-RUN must be ignored
        wait_ready("midstart");
        v = model(4'd2, 8'h3C, 8'h11);
        start = 1; op = v.op; a = v.a; b = v.b;
        k = 0; got = 0; dcnt = 0;
        while (k < 40 && !got) begin
            @(negedge clk); k++;
            start = (k == 3);
            op = (k == 3) ? 4'd0 : v.op;
            if (done) got = 1;
        end
        check("midstart_latency", k, 9);
        check("midstart_result", int'(result), int'(v.res));
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (done) dcnt++; end
        check("midstart_no_extra_done", dcnt, 0);

        // START held through FIN is taken only in the following IDLE cycle
        wait_ready("fin");
        v = model(4'd1, 8'h50, 8'h05);
        start = 1; op = v.op; a = v.a; b = v.b;
        k = 0; got = 0;
        while (k < 40 && !got) begin @(negedge clk); k++; if (done) got = 1; end
        v = model(4'd2, 8'h01, 8'h01);
        op = v.op; a = v.a; b = v.b;
        @(negedge clk);
        check("fin_idle_ready", int'(ready), 1);
        k = 0; got = 0;
        while (k < 40 && !got) begin
            @(negedge clk); k++;
            if (k == 1) start = 0;
            if (done) got = 1;
        end
        check("fin_next_latency", k, 9);
        check("fin_next_result", int'(result), int'(v.res));

        // Reset at idx=4 aborts with no DONE
        @(negedge clk);
        v = model(4'd2, 8'h0F, 8'h0F);
        start = 1; op = v.op; a = v.a; b = v.b;
        dcnt = 0;
        for (int i = 1; i <= 5; i++) begin @(negedge clk); start = 0; if (done) dcnt++; end
        rst_n = 0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_result", int'(result), 0);
        check("abort_sl", int'({sl_a, sl_b, sl_cin, sl_operation}), 0);
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) dcnt++; end
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (done) dcnt++; end
        check("abort_no_done", dcnt, 0);
        run_op(tbl[3], "after_abort_slt");
        run_op(tbl[0], "after_abort_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
